uart_tx_arbiter: RTL

- Shares one uart_tx byte transmitter among NUM_REQ requesters using a round-robin scheme.
- Captures the winning requester's byte, pulses uart_tx start, then waits for uart_tx done before serving the next request.
- A watchdog recovers the arbiter if done never arrives.
- Sits between the on-chip byte producers and the uart_tx instance.

---
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter : round-robin sharing of one uart_tx among NUM_REQ sources
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic [7:0]         req_byte [NUM_REQ];
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   cand;
  logic               found;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign req_byte[i] = req_data[8*i +: 8];
  end

  // Scan offsets from farthest to nearest so the requester closest after
  // the last grant overwrites any earlier hit.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int off = NUM_REQ; off > 0; off--) begin
      cand = IDX_W'((int'(last_q) + off) % NUM_REQ);
      if (req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    timer_d    = timer_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          tx_data_d  = req_byte[winner];
          owner_d    = winner;
          last_d     = winner;
          ack_d      = NUM_REQ'(1) << winner;
          tx_start_d = 1'b1;
          busy_d     = 1'b1;
          timer_d    = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (timer_q != TMR_W'(TIMEOUT)) begin
          timer_d = timer_q + 1'b1;
        end
        // tx_done has priority over a watchdog expiry on the same edge.
        if (tx_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= IDX_W'(NUM_REQ - 1);
      owner_q    <= '0;
      tx_data_q  <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      tx_data_q  <= tx_data_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      timer_q    <= timer_d;
    end
  end

  assign ack      = ack_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign owner    = owner_q;
  assign err      = err_q;

endmodule

`default_nettype wire
